systolic_ctrl: RTL

- Sequencer for the 3x3 weight-stationary systolic array: loads 9 weights from a weight buffer, latches them into the array, then streams activation vectors into the three west row inputs with per-row skew.
- Captures the bottom-row south outputs, de-skews them and emits one 3-word result vector per input vector.
- Sits between the local weight/activation SRAMs and the array; started by the layer scheduler with a start/done handshake.

---
 rtl/systolic_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequencer for a 3x3 weight-stationary systolic array.
//   Loads 9 weights from the weight buffer into shadow registers, pulses the
//   array weight latch, then streams activation vectors into the west row
//   inputs with a one-cycle skew per row. Bottom-row south outputs are
//   de-skewed and emitted as one {y2,y1,y0} result vector per input vector.
//
// Ports:
//   clk, rst                 clock / asynchronous active-low reset
//   start, num_vec           run request + vector count (sampled in IDLE)
//   busy, done               run status / one-cycle end-of-run pulse
//   w_rd_en/addr/data        weight buffer read port (1-cycle read latency)
//   act_rd_en/addr/data      activation buffer read port (1-cycle latency)
//   weight_en, weight_bus    array weight latch strobe and shadow weights
//   compute                  array compute enable
//   west0/3/6                skewed row inputs
//   south6/7/8               bottom-row array outputs
//   res_valid, res_data      de-skewed result vectors (no backpressure)
//
// Build option: SYS_CTRL_WEIGHT_REUSE_EN adds input reuse_w; a run started
// with reuse_w=1 skips weight loading and keeps the array's current weights.
module systolic_ctrl #(
  parameter int DATA_W  = 16,
  parameter int VEC_AW  = 4,
  parameter int OUT_LAT = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [VEC_AW-1:0]   num_vec,
`ifdef SYS_CTRL_WEIGHT_REUSE_EN
  input  logic                reuse_w,
`endif
  output logic                busy,
  output logic                done,
  output logic                w_rd_en,
  output logic [3:0]          w_rd_addr,
  input  logic [DATA_W-1:0]   w_rd_data,
  output logic                act_rd_en,
  output logic [VEC_AW-1:0]   act_rd_addr,
  input  logic [3*DATA_W-1:0] act_rd_data,
  output logic                weight_en,
  output logic [9*DATA_W-1:0] weight_bus,
  output logic                compute,
  output logic [DATA_W-1:0]   west0,
  output logic [DATA_W-1:0]   west3,
  output logic [DATA_W-1:0]   west6,
  input  logic [DATA_W-1:0]   south6,
  input  logic [DATA_W-1:0]   south7,
  input  logic [DATA_W-1:0]   south8,
  output logic                res_valid,
  output logic [3*DATA_W-1:0] res_data
);

  // Column 2 is sampled last, OUT_LAT+2 cycles after its vector's x0 hits west0.
  localparam int STAGES = OUT_LAT + 2;

  typedef enum logic [2:0] {IDLE, LOAD_W, WLATCH, FEED, DRAIN, DONE} state_t;

  state_t                   state;
  logic [VEC_AW-1:0]        last_idx;
  logic                     reuse;
  logic                     w_vld_d;
  logic [3:0]               w_idx_d;
  logic [8:0][DATA_W-1:0]   shadow;
  logic [STAGES:0]          vld_pipe;   // [k]: activation word valid k cycles ago
  logic [DATA_W-1:0]        x1_d, x2_d1, x2_d2;
  logic [DATA_W-1:0]        s6_d1, s6_d2, s7_d1;

`ifdef SYS_CTRL_WEIGHT_REUSE_EN
  assign reuse = reuse_w;
`else
  assign reuse = 1'b0;
`endif

  assign weight_bus = shadow;

  // Row 0 is unskewed, so the read data feeds west0 in the cycle it arrives.
  assign west0 = vld_pipe[0] ? act_rd_data[DATA_W-1:0] : '0;
  assign west3 = x1_d;
  assign west6 = x2_d2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      w_rd_en     <= 1'b0;
      w_rd_addr   <= '0;
      act_rd_en   <= 1'b0;
      act_rd_addr <= '0;
      weight_en   <= 1'b0;
      compute     <= 1'b0;
      last_idx    <= '0;
    end else begin
      done      <= 1'b0;
      weight_en <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          busy     <= 1'b1;
          last_idx <= num_vec - VEC_AW'(1);
          if (num_vec == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (reuse) begin
            state       <= FEED;
            act_rd_en   <= 1'b1;
            act_rd_addr <= '0;
            compute     <= 1'b1;
          end else begin
            state     <= LOAD_W;
            w_rd_en   <= 1'b1;
            w_rd_addr <= '0;
          end
        end
        // Nine read cycles, then one idle cycle while word 8 lands.
        LOAD_W: begin
          if (!w_rd_en) begin
            state     <= WLATCH;
            weight_en <= 1'b1;
          end else if (w_rd_addr == 4'd8) begin
            w_rd_en <= 1'b0;
          end else begin
            w_rd_addr <= w_rd_addr + 4'd1;
          end
        end
        WLATCH: begin
          state       <= FEED;
          act_rd_en   <= 1'b1;
          act_rd_addr <= '0;
          compute     <= 1'b1;
        end
        FEED: begin
          if (act_rd_addr == last_idx) begin
            act_rd_en <= 1'b0;
            state     <= DRAIN;
          end else begin
            act_rd_addr <= act_rd_addr + VEC_AW'(1);
          end
        end
        // Leave once the final result is on the output and nothing is in flight.
        DRAIN: if (res_valid && vld_pipe == '0) begin
          state   <= DONE;
          done    <= 1'b1;
          compute <= 1'b0;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_vld_d   <= 1'b0;
      w_idx_d   <= '0;
      shadow    <= '0;
      vld_pipe  <= '0;
      x1_d      <= '0;
      x2_d1     <= '0;
      x2_d2     <= '0;
      s6_d1     <= '0;
      s6_d2     <= '0;
      s7_d1     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      // Read data returns a cycle after the strobe; capture with delayed index.
      w_vld_d <= w_rd_en;
      w_idx_d <= w_rd_addr;
      if (w_vld_d) shadow[w_idx_d] <= w_rd_data;

      vld_pipe <= {vld_pipe[STAGES-1:0], act_rd_en};

      // Input skew: row 1 one cycle late, row 2 two cycles late.
      x1_d  <= vld_pipe[0] ? act_rd_data[DATA_W +: DATA_W]   : '0;
      x2_d1 <= vld_pipe[0] ? act_rd_data[2*DATA_W +: DATA_W] : '0;
      x2_d2 <= x2_d1;

      // Output de-skew: column c emerges c cycles after column 0.
      s6_d1 <= south6;
      s6_d2 <= s6_d1;
      s7_d1 <= south7;

      res_valid <= vld_pipe[STAGES];
      res_data  <= vld_pipe[STAGES] ? {south8, s7_d1, s6_d2} : '0;
    end
  end

endmodule
